pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipelined MIPS core. It watches the decode and execute stages and generates PC/IF-ID hold, ID-EX bubble and squash (flush) controls. It also sequences the end-of-program drain and keeps a saturating stall-cycle counter. It replaces the per-stage ad-hoc stall wiring between Fetch, Decode and Execute.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/load_use_detect.sv | 32 +++
 rtl/pipeline_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Brief    : Shared constants for the pipeline hazard/sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int REG_W   = 5;
    localparam int STATE_W = 2;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam logic [STATE_W-1:0] ST_RUN   = 2'd0;
    localparam logic [STATE_W-1:0] ST_FLUSH = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Combinational load-use hazard check between EX load and ID reads.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [REG_W-1:0] i_ex_target,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_src1,
    input  logic [REG_W-1:0] i_id_src2,
    input  logic             i_id_src1_used,
    input  logic             i_id_src2_used,
    output logic             o_lu
);

    logic w_ex_load_live;
    logic w_src1_hit;
    logic w_src2_hit;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign w_ex_load_live = i_ex_valid && i_ex_is_load && (i_ex_target != REG_ZERO);
    assign w_src1_hit     = i_id_src1_used && (i_id_src1 == i_ex_target);
    assign w_src2_hit     = i_id_src2_used && (i_id_src2 == i_ex_target);
    assign o_lu           = w_ex_load_live && i_id_valid && (w_src1_hit || w_src2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Hazard, flush and end-of-program sequencing for the 5-stage core.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk_x70,
    input  logic             rst_n_x70,
    input  logic             id_valid_x70,
    input  logic [REG_W-1:0] id_src1_x70,
    input  logic [REG_W-1:0] id_src2_x70,
    input  logic             id_src1_used_x70,
    input  logic             id_src2_used_x70,
    input  logic             ex_valid_x70,
    input  logic             ex_is_load_x70,
    input  logic [REG_W-1:0] ex_target_x70,
    input  logic             ex_mispredict_x70,
    input  logic             halt_seen_x70,
    output logic             pc_hold_x70,
    output logic             id_bubble_x70,
    output logic             flush_x70,
    output logic [1:0]       state_x70,
    output logic [CNT_W-1:0] stall_cnt_x70,
    output logic             finished_x70
);

    localparam int c_MAX_CYC = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
    localparam int c_DCNT_W  = (c_MAX_CYC < 2) ? 1 : $clog2(c_MAX_CYC);

    localparam logic [c_DCNT_W-1:0] c_FLUSH_LOAD =
        c_DCNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
    localparam logic [c_DCNT_W-1:0] c_DRAIN_LOAD = c_DCNT_W'(DRAIN_CYCLES - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_ZERO  = '0;
    localparam logic [c_DCNT_W-1:0] c_DCNT_ONE   = c_DCNT_W'(1);
    // A single-cycle flush is fully covered by the mispredict cycle itself
    localparam logic [STATE_W-1:0]  c_FLUSH_DEST = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    localparam logic [CNT_W-1:0]    c_STALL_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_STALL_ONE  = CNT_W'(1);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_state_nxt;
    logic [c_DCNT_W-1:0] r_dcnt;
    logic [c_DCNT_W-1:0] w_dcnt_nxt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                r_finished;
    logic                w_lu;
    logic                w_hold;
    logic                w_bubble;
    logic                w_flush;
    logic                w_count_en;

    load_use_detect u_load_use_detect (
        .i_ex_valid     (ex_valid_x70),
        .i_ex_is_load   (ex_is_load_x70),
        .i_ex_target    (ex_target_x70),
        .i_id_valid     (id_valid_x70),
        .i_id_src1      (id_src1_x70),
        .i_id_src2      (id_src2_x70),
        .i_id_src1_used (id_src1_used_x70),
        .i_id_src2_used (id_src2_used_x70),
        .o_lu           (w_lu)
    );

    always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
        if (!rst_n_x70) begin
            r_state <= ST_RUN;
            r_dcnt  <= c_DCNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            ST_RUN: begin
                // Mispredict outranks halt: a halt fetched down the wrong path is dropped
                if (ex_mispredict_x70) begin
                    w_state_nxt = c_FLUSH_DEST;
                    w_dcnt_nxt  = c_FLUSH_LOAD;
                end else if (!w_lu && halt_seen_x70) begin
                    w_state_nxt = ST_DRAIN;
                    w_dcnt_nxt  = c_DRAIN_LOAD;
                end
            end
            ST_FLUSH: begin
                if (ex_mispredict_x70) begin
                    w_dcnt_nxt = c_FLUSH_LOAD;
                end else if (r_dcnt == c_DCNT_ZERO) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_dcnt_nxt = r_dcnt - c_DCNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (ex_mispredict_x70) begin
                    w_state_nxt = c_FLUSH_DEST;
                    w_dcnt_nxt  = c_FLUSH_LOAD;
                end else if (r_dcnt == c_DCNT_ZERO) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_dcnt_nxt = r_dcnt - c_DCNT_ONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_dcnt_nxt  = c_DCNT_ZERO;
            end
        endcase
    end

    // Gated by reset so no stray control pulse escapes while rst_n is low
    always_comb begin
        w_hold   = 1'b0;
        w_bubble = 1'b0;
        w_flush  = 1'b0;
        if (rst_n_x70) begin
            case (r_state)
                ST_RUN: begin
                    if (ex_mispredict_x70) begin
                        w_flush = 1'b1;
                    end else if (w_lu) begin
                        w_hold   = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    w_flush = 1'b1;
                end
                ST_DRAIN: begin
                    w_hold  = 1'b1;
                    w_flush = ex_mispredict_x70;
                end
                ST_DONE: begin
                    w_hold = 1'b1;
                end
                default: begin
                    w_hold = 1'b0;
                end
            endcase
        end
    end

    assign w_count_en = (w_hold || w_flush) && ((r_state == ST_RUN) || (r_state == ST_FLUSH));

    always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
        if (!rst_n_x70) begin
            r_stall_cnt <= '0;
            r_finished  <= 1'b0;
        end else begin
            if (w_count_en && (r_stall_cnt != c_STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_STALL_ONE;
            end
            r_finished <= (w_state_nxt == ST_DONE);
        end
    end

    assign pc_hold_x70   = w_hold;
    assign id_bubble_x70 = w_bubble;
    assign flush_x70     = w_flush;
    assign state_x70     = r_state;
    assign stall_cnt_x70 = r_stall_cnt;
    assign finished_x70  = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed self-checking bench for pipeline_ctrl (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic        clk_x70 = 1'b0;
    logic        rst_n_x70;
    logic        id_valid_x70;
    logic [4:0]  id_src1_x70;
    logic [4:0]  id_src2_x70;
    logic        id_src1_used_x70;
    logic        id_src2_used_x70;
    logic        ex_valid_x70;
    logic        ex_is_load_x70;
    logic [4:0]  ex_target_x70;
    logic        ex_mispredict_x70;
    logic        halt_seen_x70;
    logic        pc_hold_x70;
    logic        id_bubble_x70;
    logic        flush_x70;
    logic [1:0]  state_x70;
    logic [15:0] stall_cnt_x70;
    logic        finished_x70;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   exp_cnt   = 0;

    always #5 clk_x70 = ~clk_x70;

    pipeline_ctrl #(
        .FLUSH_CYCLES (2),
        .DRAIN_CYCLES (4),
        .CNT_W        (16)
    ) dut (
        .clk_x70           (clk_x70),
        .rst_n_x70         (rst_n_x70),
        .id_valid_x70      (id_valid_x70),
        .id_src1_x70       (id_src1_x70),
        .id_src2_x70       (id_src2_x70),
        .id_src1_used_x70  (id_src1_used_x70),
        .id_src2_used_x70  (id_src2_used_x70),
        .ex_valid_x70      (ex_valid_x70),
        .ex_is_load_x70    (ex_is_load_x70),
        .ex_target_x70     (ex_target_x70),
        .ex_mispredict_x70 (ex_mispredict_x70),
        .halt_seen_x70     (halt_seen_x70),
        .pc_hold_x70       (pc_hold_x70),
        .id_bubble_x70     (id_bubble_x70),
        .flush_x70         (flush_x70),
        .state_x70         (state_x70),
        .stall_cnt_x70     (stall_cnt_x70),
        .finished_x70      (finished_x70)
    );

    task automatic idle();
        id_valid_x70      = 1'b0;
        id_src1_x70       = 5'd0;
        id_src2_x70       = 5'd0;
        id_src1_used_x70  = 1'b0;
        id_src2_used_x70  = 1'b0;
        ex_valid_x70      = 1'b0;
        ex_is_load_x70    = 1'b0;
        ex_target_x70     = 5'd0;
        ex_mispredict_x70 = 1'b0;
        halt_seen_x70     = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] tgt, input logic [4:0] src2);
        ex_valid_x70     = 1'b1;
        ex_is_load_x70   = 1'b1;
        ex_target_x70    = tgt;
        id_valid_x70     = 1'b1;
        id_src2_x70      = src2;
        id_src2_used_x70 = 1'b1;
    endtask

    // Inputs are already applied; expectation is queued, compared, then one clock advances.
    task automatic chk(input string tag, input logic h, input logic b, input logic f,
                       input logic [1:0] st, input logic fin);
        exp_t        e;
        exp_t        got;
        logic [21:0] obs;
        e.tag = tag;
        e.v   = {h, b, f, st, 16'(exp_cnt), fin};
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        obs = {pc_hold_x70, id_bubble_x70, flush_x70, state_x70, stall_cnt_x70, finished_x70};
        checks++;
        assert (obs === got.v) else begin
            failures++;
            $error("FAIL %s observed hold/bub/flush/state/cnt/fin=%b/%b/%b/%0d/%0d/%b expected=%b/%b/%b/%0d/%0d/%b",
                   got.tag, obs[21], obs[20], obs[19], obs[18:17], obs[16:1], obs[0],
                   got.v[21], got.v[20], got.v[19], got.v[18:17], got.v[16:1], got.v[0]);
        end
        if ((h || f) && (st == ST_RUN || st == ST_FLUSH) && exp_cnt < 65535) exp_cnt++;
        @(posedge clk_x70);
        #1;
    endtask

    initial begin
        rst_n_x70 = 1'b0;
        idle();
        ex_mispredict_x70 = 1'b1;
        set_lu(5'd5, 5'd5);
        @(posedge clk_x70);
        #1;
        chk("reset_quiet", 0, 0, 0, ST_RUN, 0);
        rst_n_x70 = 1'b1;
        idle();
        chk("idle_run", 0, 0, 0, ST_RUN, 0);

        // Load-use on src2, then several non-hazard variants
        set_lu(5'd5, 5'd5);
        chk("lu_src2", 1, 1, 0, ST_RUN, 0);
        idle();
        chk("lu_one_cycle", 0, 0, 0, ST_RUN, 0);
        set_lu(5'd5, 5'd6);
        id_src2_used_x70 = 1'b0;
        id_src1_x70      = 5'd5;
        chk("lu_src1_unused", 0, 0, 0, ST_RUN, 0);
        id_src1_used_x70 = 1'b1;
        chk("lu_src1", 1, 1, 0, ST_RUN, 0);
        idle();
        set_lu(5'd0, 5'd0);
        chk("lu_r0_target", 0, 0, 0, ST_RUN, 0);
        set_lu(5'd7, 5'd7);
        ex_is_load_x70 = 1'b0;
        chk("lu_not_load", 0, 0, 0, ST_RUN, 0);
        set_lu(5'd7, 5'd7);
        id_valid_x70 = 1'b0;
        chk("lu_id_invalid", 0, 0, 0, ST_RUN, 0);
        idle();

        // Mispredict: two flush cycles
        ex_mispredict_x70 = 1'b1;
        chk("mp_run", 0, 0, 1, ST_RUN, 0);
        ex_mispredict_x70 = 1'b0;
        chk("mp_flush", 0, 0, 1, ST_FLUSH, 0);
        chk("mp_back_run", 0, 0, 0, ST_RUN, 0);

        // Second mispredict inside FLUSH extends it; lu ignored in FLUSH
        ex_mispredict_x70 = 1'b1;
        chk("mp2_run", 0, 0, 1, ST_RUN, 0);
        set_lu(5'd3, 5'd3);
        chk("mp2_in_flush", 0, 0, 1, ST_FLUSH, 0);
        ex_mispredict_x70 = 1'b0;
        chk("mp2_extended", 0, 0, 1, ST_FLUSH, 0);
        idle();
        chk("mp2_back_run", 0, 0, 0, ST_RUN, 0);

        // Mispredict + lu + halt together: flush only
        set_lu(5'd9, 5'd9);
        ex_mispredict_x70 = 1'b1;
        halt_seen_x70     = 1'b1;
        chk("combo_run", 0, 0, 1, ST_RUN, 0);
        idle();
        chk("combo_flush", 0, 0, 1, ST_FLUSH, 0);
        chk("combo_no_drain", 0, 0, 0, ST_RUN, 0);

        // Halt -> 4 drain cycles -> DONE
        halt_seen_x70 = 1'b1;
        chk("halt_run", 0, 0, 0, ST_RUN, 0);
        halt_seen_x70 = 1'b0;
        for (int i = 0; i < 4; i++) chk("drain", 1, 0, 0, ST_DRAIN, 0);
        chk("done", 1, 0, 0, ST_DONE, 1);
        set_lu(5'd4, 5'd4);
        ex_mispredict_x70 = 1'b1;
        chk("done_ignores", 1, 0, 0, ST_DONE, 1);

        // Asynchronous reset out of DONE
        rst_n_x70 = 1'b0;
        exp_cnt   = 0;
        chk("rst_from_done", 0, 0, 0, ST_RUN, 0);
        rst_n_x70 = 1'b1;
        idle();
        chk("post_rst_idle", 0, 0, 0, ST_RUN, 0);

        // Mispredict at drain cycle 2 cancels the halt
        halt_seen_x70 = 1'b1;
        chk("halt2_run", 0, 0, 0, ST_RUN, 0);
        halt_seen_x70 = 1'b0;
        chk("drain2_c1", 1, 0, 0, ST_DRAIN, 0);
        ex_mispredict_x70 = 1'b1;
        chk("drain2_mp", 1, 0, 1, ST_DRAIN, 0);
        ex_mispredict_x70 = 1'b0;
        chk("drain2_flush", 0, 0, 1, ST_FLUSH, 0);
        for (int i = 0; i < 5; i++) chk("drain2_no_finish", 0, 0, 0, ST_RUN, 0);

        // Reset mid-DRAIN with a mispredict pending: no residual pulses
        halt_seen_x70 = 1'b1;
        chk("halt3_run", 0, 0, 0, ST_RUN, 0);
        halt_seen_x70 = 1'b0;
        chk("drain3_c1", 1, 0, 0, ST_DRAIN, 0);
        ex_mispredict_x70 = 1'b1;
        rst_n_x70 = 1'b0;
        exp_cnt   = 0;
        chk("rst_mid_drain", 0, 0, 0, ST_RUN, 0);
        rst_n_x70 = 1'b1;
        idle();
        chk("post_rst2_idle", 0, 0, 0, ST_RUN, 0);
        set_lu(5'd5, 5'd5);
        chk("post_rst2_lu", 1, 1, 0, ST_RUN, 0);
        idle();
        chk("post_rst2_cnt", 0, 0, 0, ST_RUN, 0);

        // 70000 back-to-back hazard cycles saturate the 16-bit counter
        set_lu(5'd12, 5'd12);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk_x70);
            if (exp_cnt < 65535) exp_cnt++;
        end
        #1;
        chk("sat_hold", 1, 1, 0, ST_RUN, 0);
        idle();
        chk("sat_stays", 0, 0, 0, ST_RUN, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
